// File: rtl/parking_slot_manager_pkg.sv
// Shared types for the parking slot manager slice.
//   op_e    : request opcode carried on req_op
//   state_e : transaction FSM states (accept, execute, respond)
package parking_pkg;

  typedef enum logic [1:0] {
    OP_PARK_AT  = 2'b00,
    OP_LEAVE    = 2'b01,
    OP_PARK_ANY = 2'b10,
    OP_RSVD     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

endpackage

// File: rtl/parking_slot_manager_if.sv
// Request/response channel of the parking slot manager.
//   req_valid/req_ready/req_op/req_slot : one park/leave request
//   rsp_valid/rsp_ready/rsp_ok/rsp_slot : status response for that request
// master = gate/sensor controller side, slave = manager side.
interface parking_slot_manager_if
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
);
  logic             req_valid;
  logic             req_ready;
  op_e              req_op;
  logic [IDX_W-1:0] req_slot;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_ok;
  logic [IDX_W-1:0] rsp_slot;

  modport master (
    output req_valid, req_op, req_slot, rsp_ready,
    input  req_ready, rsp_valid, rsp_ok, rsp_slot
  );

  modport slave (
    input  req_valid, req_op, req_slot, rsp_ready,
    output req_ready, rsp_valid, rsp_ok, rsp_slot
  );
endinterface

// File: rtl/parking_slot_manager_finder.sv
// Priority encoder that locates the lowest-index free slot.
//   occupancy : slot map, 1 = taken
//   found     : at least one slot is free
//   idx       : index of the lowest free slot (0 when none)
module lowest_free_finder #(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!found && !occupancy[IDX_W'(i)]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/parking_slot_manager.sv
// Parking occupancy manager: owns the slot map, serves one park/leave
// request at a time and returns a status response.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   bus         : request/response channel (slave side)
//   occupancy   : registered slot map, 1 = taken
//   free_count  : registered number of free slots
//   full, empty : free_count == 0 / free_count == NUM_SLOTS
module parking_slot_manager
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = $clog2(NUM_SLOTS),
  parameter int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  parking_slot_manager_if.slave   bus,
  output logic [NUM_SLOTS-1:0]    occupancy,
  output logic [CNT_W-1:0]        free_count,
  output logic                    full,
  output logic                    empty
);

  // One extra bit so a non-power-of-two slot count can be range checked.
  localparam logic [IDX_W:0] SLOT_LIMIT = (IDX_W + 1)'(NUM_SLOTS);

  state_e                 state_q, state_d;
  op_e                    op_q;
  logic [IDX_W-1:0]       slot_q;
  logic [NUM_SLOTS-1:0]   occ_q, occ_d;
  logic [CNT_W-1:0]       free_q, free_d;
  logic                   ok_q, ok_d;
  logic [IDX_W-1:0]       rsp_slot_q, rsp_slot_d;
  logic                   any_found;
  logic [IDX_W-1:0]       any_idx;
  logic                   slot_in_range;

  lowest_free_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_finder (
    .occupancy (occ_q),
    .found     (any_found),
    .idx       (any_idx)
  );

  assign slot_in_range = {1'b0, slot_q} < SLOT_LIMIT;

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    free_d     = free_q;
    ok_d       = ok_q;
    rsp_slot_d = rsp_slot_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) state_d = S_EXEC;
      S_EXEC: begin
        state_d    = S_RESP;
        ok_d       = 1'b0;
        rsp_slot_d = slot_q;
        case (op_q)
          OP_PARK_AT: begin
            if (slot_in_range && !occ_q[slot_q]) begin
              occ_d[slot_q] = 1'b1;
              free_d        = free_q - CNT_W'(1);
              ok_d          = 1'b1;
            end
          end
          OP_LEAVE: begin
            if (slot_in_range && occ_q[slot_q]) begin
              occ_d[slot_q] = 1'b0;
              free_d        = free_q + CNT_W'(1);
              ok_d          = 1'b1;
            end
          end
          OP_PARK_ANY: begin
            rsp_slot_d = '0;
            if (any_found) begin
              occ_d[any_idx] = 1'b1;
              free_d         = free_q - CNT_W'(1);
              ok_d           = 1'b1;
              rsp_slot_d     = any_idx;
            end
          end
          default: ;
        endcase
      end
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_PARK_AT;
      slot_q     <= '0;
      occ_q      <= '0;
      free_q     <= CNT_W'(NUM_SLOTS);
      ok_q       <= 1'b0;
      rsp_slot_q <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      free_q     <= free_d;
      ok_q       <= ok_d;
      rsp_slot_q <= rsp_slot_d;
      if (state_q == S_IDLE && bus.req_valid) begin
        op_q   <= bus.req_op;
        slot_q <= bus.req_slot;
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_ok    = ok_q;
  assign bus.rsp_slot  = rsp_slot_q;
  assign occupancy     = occ_q;
  assign free_count    = free_q;
  assign full          = (free_q == '0);
  assign empty         = (free_q == CNT_W'(NUM_SLOTS));

endmodule

// File: tb/tb_parking_slot_manager.sv
module tb_parking_slot_manager;
  import parking_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_slot_manager_if #(.NUM_SLOTS(8)) bus8 ();
  parking_slot_manager_if #(.NUM_SLOTS(5)) bus5 ();

  logic [7:0] occ8;
  logic [3:0] free8;
  logic       full8, empty8;
  logic [4:0] occ5;
  logic [2:0] free5;
  logic       full5, empty5;

  parking_slot_manager #(.NUM_SLOTS(8)) dut8 (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus8),
    .occupancy  (occ8),
    .free_count (free8),
    .full       (full8),
    .empty      (empty8)
  );

  parking_slot_manager #(.NUM_SLOTS(5)) dut5 (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus5),
    .occupancy  (occ5),
    .free_count (free5),
    .full       (full5),
    .empty      (empty5)
  );

  typedef struct {
    logic       ok;
    logic [2:0] slot;
    bit         chk_slot;
    logic [7:0] occ;
    logic [3:0] free;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_occ;
  int         passed = 0;
  int         failed = 0;
  int         total  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one request against the 8-slot map.
  task automatic model(input op_e op, input logic [2:0] slot, output exp_t e);
    e.ok       = 1'b0;
    e.slot     = slot;
    e.chk_slot = 1'b1;
    case (op)
      OP_PARK_AT:
        if (!ref_occ[slot]) begin ref_occ[slot] = 1'b1; e.ok = 1'b1; end
        else e.chk_slot = 1'b0;
      OP_LEAVE:
        if (ref_occ[slot]) begin ref_occ[slot] = 1'b0; e.ok = 1'b1; end
        else e.chk_slot = 1'b0;
      OP_PARK_ANY: begin
        e.slot = 3'd0;
        for (int i = 0; i < 8; i++) begin
          if (!ref_occ[i]) begin
            ref_occ[i] = 1'b1;
            e.ok       = 1'b1;
            e.slot     = 3'(i);
            break;
          end
        end
      end
      default: ;
    endcase
    e.occ  = ref_occ;
    e.free = 4'(8 - $countones(ref_occ));
  endtask

  task automatic send(input op_e op, input logic [2:0] slot, input bit track);
    exp_t e;
    int   n;
    n = 0;
    if (track) begin
      model(op, slot, e);
      sb.push_back(e);
    end
    @(negedge clk);
    bus8.req_valid = 1'b1;
    bus8.req_op    = op;
    bus8.req_slot  = slot;
    while (!bus8.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus8.req_ready) check("accept_timeout", 32'(bus8.req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request lines: the manager must have latched them.
    bus8.req_valid = 1'b0;
    bus8.req_op    = OP_RSVD;
    bus8.req_slot  = ~slot;
  endtask

  task automatic get_rsp(output int waited);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!bus8.rsp_valid && n < 20) begin @(negedge clk); n++; end
    waited = n;
    check("rsp_valid", 32'(bus8.rsp_valid), 32'd1);
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_ok", 32'(bus8.rsp_ok), 32'(e.ok));
      if (e.chk_slot) check("rsp_slot", 32'(bus8.rsp_slot), 32'(e.slot));
      check("occupancy", 32'(occ8), 32'(e.occ));
      check("free_count", 32'(free8), 32'(e.free));
      check("full", 32'(full8), 32'(e.free == 4'd0));
      check("empty", 32'(empty8), 32'(e.free == 4'd8));
    end
    bus8.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.rsp_ready = 1'b0;
    check("req_ready_after_rsp", 32'(bus8.req_ready), 32'd1);
  endtask

  task automatic txn(input op_e op, input logic [2:0] slot);
    int w;
    send(op, slot, 1'b1);
    get_rsp(w);
  endtask

  task automatic txn5(input op_e op, input logic [2:0] slot, input logic exp_ok,
                      input logic [2:0] exp_slot, input logic [4:0] exp_occ,
                      input logic [2:0] exp_free);
    int n;
    n = 0;
    @(negedge clk);
    bus5.req_valid = 1'b1;
    bus5.req_op    = op;
    bus5.req_slot  = slot;
    while (!bus5.req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    bus5.req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus5.rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("n5_rsp_valid", 32'(bus5.rsp_valid), 32'd1);
    check("n5_rsp_ok", 32'(bus5.rsp_ok), 32'(exp_ok));
    if (exp_ok || op == OP_PARK_ANY) check("n5_rsp_slot", 32'(bus5.rsp_slot), 32'(exp_slot));
    check("n5_occupancy", 32'(occ5), 32'(exp_occ));
    check("n5_free_count", 32'(free5), 32'(exp_free));
    bus5.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus5.rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset          = 1'b1;
    ref_occ        = 8'h00;
    bus8.req_valid = 1'b0;
    bus8.req_op    = OP_PARK_AT;
    bus8.req_slot  = 3'd0;
    bus8.rsp_ready = 1'b0;
    bus5.req_valid = 1'b0;
    bus5.req_op    = OP_PARK_AT;
    bus5.req_slot  = 3'd0;
    bus5.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_occupancy", 32'(occ8), 32'h00);
    check("rst_free_count", 32'(free8), 32'd8);
    check("rst_empty", 32'(empty8), 32'd1);
    check("rst_full", 32'(full8), 32'd0);
    check("rst_req_ready", 32'(bus8.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus8.rsp_valid), 32'd0);
    check("rst_rsp_ok", 32'(bus8.rsp_ok), 32'd0);

    // PARK_AT 3 twice; first response also checks one-cycle execute latency
    send(OP_PARK_AT, 3'd3, 1'b1);
    get_rsp(w);
    check("latency", 32'(w), 32'd1);
    check("t2_occ", 32'(occ8), 32'h08);
    check("t2_free", 32'(free8), 32'd7);
    txn(OP_PARK_AT, 3'd3);
    check("t2_occ_unchanged", 32'(occ8), 32'h08);
    txn(OP_LEAVE, 3'd3);

    // PARK_ANY fills 0..7 in order, then rejects
    for (int i = 0; i < 8; i++) txn(OP_PARK_ANY, 3'd7);
    check("t3_full", 32'(full8), 32'd1);
    check("t3_free", 32'(free8), 32'd0);
    txn(OP_PARK_ANY, 3'd5);
    check("t3_reject_slot", 32'(bus8.rsp_slot), 32'd0);

    // LEAVE on full map, refill hole, LEAVE on empty slot, reserved op
    txn(OP_LEAVE, 3'd2);
    check("t4_occ", 32'(occ8), 32'hFB);
    check("t4_free", 32'(free8), 32'd1);
    txn(OP_PARK_ANY, 3'd0);
    txn(OP_LEAVE, 3'd5);
    txn(OP_LEAVE, 3'd5);
    txn(OP_RSVD, 3'd6);

    // Back-pressure: response held while rsp_ready is low, new requests ignored
    send(OP_PARK_AT, 3'd5, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 5 && !bus8.rsp_valid; i++) @(negedge clk);
    bus8.req_valid = 1'b1;
    bus8.req_op    = OP_LEAVE;
    bus8.req_slot  = 3'd1;
    for (int i = 0; i < 4; i++) begin
      check("bp_rsp_valid", 32'(bus8.rsp_valid), 32'd1);
      check("bp_rsp_ok", 32'(bus8.rsp_ok), 32'd1);
      check("bp_rsp_slot", 32'(bus8.rsp_slot), 32'd5);
      check("bp_req_ready", 32'(bus8.req_ready), 32'd0);
      @(negedge clk);
    end
    bus8.req_valid = 1'b0;
    get_rsp(w);
    check("bp_occ_full", 32'(occ8), 32'hFF);

    // Reset during EXEC aborts the transaction and clears the map
    txn(OP_LEAVE, 3'd1);
    send(OP_PARK_AT, 3'd1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    ref_occ = 8'h00;
    check("mid_rst_occ", 32'(occ8), 32'h00);
    check("mid_rst_free", 32'(free8), 32'd8);
    check("mid_rst_rsp_valid", 32'(bus8.rsp_valid), 32'd0);
    check("mid_rst_req_ready", 32'(bus8.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", 32'(bus8.rsp_valid), 32'd0);
    end
    check("post_rst_empty", 32'(empty8), 32'd1);

    // NUM_SLOTS=5 build: out-of-range slot rejected, then fill to full
    check("n5_rst_free", 32'(free5), 32'd5);
    txn5(OP_PARK_AT, 3'd6, 1'b0, 3'd0, 5'h00, 3'd5);
    txn5(OP_LEAVE, 3'd7, 1'b0, 3'd0, 5'h00, 3'd5);
    txn5(OP_PARK_AT, 3'd4, 1'b1, 3'd4, 5'h10, 3'd4);
    txn5(OP_PARK_ANY, 3'd0, 1'b1, 3'd0, 5'h11, 3'd3);
    txn5(OP_PARK_ANY, 3'd0, 1'b1, 3'd1, 5'h13, 3'd2);
    txn5(OP_PARK_ANY, 3'd0, 1'b1, 3'd2, 5'h17, 3'd1);
    txn5(OP_PARK_ANY, 3'd0, 1'b1, 3'd3, 5'h1F, 3'd0);
    check("n5_full", 32'(full5), 32'd1);
    txn5(OP_PARK_ANY, 3'd0, 1'b0, 3'd0, 5'h1F, 3'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
